// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared state encoding, default width and popcount helper for the Gray sequencer.
package gray_conv_pkg;

    localparam int GRAY_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        READ   = 3'd2,
        WAIT   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    function automatic int unsigned gray_popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/gray_input_sync.sv
// gray_input_sync: 2-flop synchroniser plus stability counter; stable_done pulses once the
// synchronised code has held for SETTLE_CYCLES consecutive cycles while en is high.
module gray_input_sync #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             reloj,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             en,
    output logic [WIDTH-1:0] g_s,
    output logic             stable_done
);

    logic [WIDTH-1:0] s1_q, gs_q, gprev_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             same;

    always_comb begin
        same        = gs_q == gprev_q;
        stable_done = en && same && cnt_q == 8'(SETTLE_CYCLES - 1);
        cnt_d       = (!en || !same || stable_done) ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            gs_q    <= '0;
            gprev_q <= '0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= gray_in;
            gs_q    <= s1_q;
            gprev_q <= gs_q;
            cnt_q   <= cnt_d;
        end
    end

    assign g_s = gs_q;

endmodule

// File: rtl/gray_conv_sequencer.sv
// gray_conv_sequencer: settles a synchronised Gray input, strobes the converter and hands the
// binary result downstream on valid/ready. Define GRAY_STEP_CHECK_EN for the sticky step_err flag.
module gray_conv_sequencer
    import gray_conv_pkg::*;
#(
    parameter int WIDTH         = GRAY_WIDTH,
    parameter int SETTLE_CYCLES = 4,
    parameter int CONV_LAT      = 1
) (
    input  logic             reloj,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic             conv_read,
    output logic [WIDTH-1:0] conv_gray,
    input  logic [WIDTH-1:0] conv_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             busy,
    output logic             step_err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] conv_gray_q, conv_gray_d, last_code_q, last_code_d, bin_out_q, bin_out_d;
    logic             bin_valid_q, bin_valid_d;
    logic [2:0]       lat_q, lat_d;
    logic [WIDTH-1:0] g_s;
    logic             stable_done;

    gray_input_sync #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES)) u_sync (
        .reloj      (reloj),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .en         (state_q == SETTLE),
        .g_s        (g_s),
        .stable_done(stable_done)
    );

    always_comb begin
        state_d     = state_q;
        conv_gray_d = conv_gray_q;
        last_code_d = last_code_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        lat_d       = lat_q;
        case (state_q)
            IDLE:   if (g_s != last_code_q) state_d = SETTLE;
            SETTLE: if (stable_done) begin
                conv_gray_d = g_s;
                last_code_d = g_s;
                state_d     = READ;
            end
            READ: begin
                lat_d = '0;
                if (CONV_LAT == 0) begin
                    bin_out_d   = conv_bin;
                    bin_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: if (lat_q == 3'(CONV_LAT - 1)) begin
                bin_out_d   = conv_bin;
                bin_valid_d = 1'b1;
                state_d     = HOLD;
            end else begin
                lat_d = lat_q + 3'd1;
            end
            HOLD: if (bin_valid_q && bin_ready) begin
                bin_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset lands in SETTLE so the code present at power-up is always converted once.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SETTLE;
            conv_gray_q <= '0;
            last_code_q <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            conv_gray_q <= conv_gray_d;
            last_code_q <= last_code_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            lat_q       <= lat_d;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic step_err_q, step_err_d, first_q, first_d;

    always_comb begin
        first_d    = first_q && !stable_done;
        step_err_d = step_err_q ||
                     (stable_done && !first_q && gray_popcount(32'(g_s ^ last_code_q)) > 1);
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            step_err_q <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            step_err_q <= step_err_d;
            first_q    <= first_d;
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

    assign conv_read = state_q == READ;
    assign conv_gray = conv_gray_q;
    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign busy      = state_q != IDLE;

endmodule
